// File: rtl/cos_pkg.sv
// Shared definitions for the cosine Maclaurin control unit.
package cos_pkg;

  // 3-bit state encoding; IDLE must stay at zero so reset lands there.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_INC  = 3'd2,
    ST_MULX = 3'd3,
    ST_MULR = 3'd4,
    ST_ACC  = 3'd5,
    ST_DONE = 3'd6
  } cos_state_e;

  // Number of series terms after the constant 1 (k = 1..7).
  localparam int N_TERMS = 7;

  // Default extra settle cycles per multiply step.
  localparam int LAT_MUL_DEF = 0;

endpackage

// File: rtl/cos_wait_cnt.sv
// Settle counter shared by the two multiply states.
// Counts up from zero while enabled and flags when it reaches LAT_MUL.
module cos_wait_cnt
  import cos_pkg::*;
#(
  parameter int WCNT_W  = 4,
  parameter int LAT_MUL = LAT_MUL_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic eq_o
);

  logic [WCNT_W-1:0] cnt_q;
  logic [WCNT_W-1:0] cnt_d;

  // Clear has priority over count so every visit starts at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + WCNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign eq_o = (cnt_q == WCNT_W'(LAT_MUL));

endmodule

// File: rtl/cos_cu.sv
// Control unit for the cosine Maclaurin datapath.
// Sequences LOAD, then INC/MULX/MULR/ACC once per term, then holds DONE until ack.
// All outputs are decoded from the state register and the settle counter only.
//
//  state | meaning
//  IDLE  | ready for a request
//  LOAD  | latch x, clear term counter, t=1, c=1
//  INC   | advance term counter
//  MULX  | t <= t*x^2 (ldT on last settle cycle)
//  MULR  | t <= t*LUT[cnt] (selXR=1, ldT on last settle cycle)
//  ACC   | c <= c +/- t; leave for DONE after the last term
//  DONE  | result valid on rBus until ack
//
// WCNT_W must be wide enough that 2^WCNT_W > LAT_MUL.
module cos_cu
  import cos_pkg::*;
#(
  parameter int LAT_MUL = LAT_MUL_DEF,
  parameter int WCNT_W  = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic abort_i,
  input  logic ack_i,
  input  logic cnt8_i,
  output logic ready_o,
  output logic busy_o,
  output logic done_o,
  output logic ld_x_o,
  output logic init0_o,
  output logic init_t1_o,
  output logic init_c1_o,
  output logic cnt_up_o,
  output logic sel_xr_o,
  output logic ld_t_o,
  output logic ld_c_o
);

  cos_state_e state_q;
  cos_state_e state_d;
  logic       in_mul;
  logic       wait_eq;
  logic       wait_en;

  assign in_mul  = (state_q == ST_MULX) || (state_q == ST_MULR);
  // Count only while settling; any other cycle clears, so each visit starts at 0.
  assign wait_en = in_mul && !wait_eq;

  cos_wait_cnt #(
    .WCNT_W (WCNT_W),
    .LAT_MUL(LAT_MUL)
  ) u_wait (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (!wait_en),
    .en_i  (wait_en),
    .eq_o  (wait_eq)
  );

  // Next-state decode; abort overrides everything else.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_INC;
      ST_INC:  state_d = ST_MULX;
      ST_MULX: if (wait_eq) state_d = ST_MULR;
      ST_MULR: if (wait_eq) state_d = ST_ACC;
      ST_ACC:  state_d = cnt8_i ? ST_DONE : ST_INC;
      ST_DONE: if (ack_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_i) begin
      state_d = ST_IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore output decode.
  always_comb begin
    ready_o   = (state_q == ST_IDLE);
    busy_o    = (state_q == ST_LOAD) || (state_q == ST_INC) || in_mul ||
                (state_q == ST_ACC);
    done_o    = (state_q == ST_DONE);
    ld_x_o    = (state_q == ST_LOAD);
    init0_o   = (state_q == ST_LOAD);
    init_t1_o = (state_q == ST_LOAD);
    init_c1_o = (state_q == ST_LOAD);
    cnt_up_o  = (state_q == ST_INC);
    sel_xr_o  = (state_q == ST_MULR);
    ld_t_o    = in_mul && wait_eq;
    ld_c_o    = (state_q == ST_ACC);
  end

endmodule

// File: tb/tb_cos_cu.sv
// Scoreboard bench for cos_cu paired with a behavioural cosine datapath model.
// Instance 0 runs with LAT_MUL=0, instance 1 with LAT_MUL=3.
module tb_cos_cu;
  import cos_pkg::*;

  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n   [NI];
  logic       start_s [NI];
  logic       abort_s [NI];
  logic       ack_s   [NI];
  logic       cnt8_s  [NI];
  logic       ready_s [NI];
  logic       busy_s  [NI];
  logic       done_s  [NI];
  logic [7:0] strb    [NI];
  int         x_in    [NI];
  int         exp_load[NI];

  int total = 0;
  int bad   = 0;
  int qx0[$];
  int qx1[$];

  task automatic check(input string name, input int act, input int exp, input int tol);
    int d;
    d = act - exp;
    if (d < 0) d = -d;
    total++;
    if (d > tol) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at %0t", name, act, exp, tol, $time);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event missing at %0t", name, $time);
  endtask

  function automatic real lut(input int k);
    return 1.0 / real'((2 * k - 1) * (2 * k));
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int L = (g == 0) ? 0 : 3;
    logic ld_x, init0, init_t1, init_c1, cnt_up, sel_xr, ld_t, ld_c;

    cos_cu #(.LAT_MUL(L), .WCNT_W(4)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n[g]),
      .start_i  (start_s[g]),
      .abort_i  (abort_s[g]),
      .ack_i    (ack_s[g]),
      .cnt8_i   (cnt8_s[g]),
      .ready_o  (ready_s[g]),
      .busy_o   (busy_s[g]),
      .done_o   (done_s[g]),
      .ld_x_o   (ld_x),
      .init0_o  (init0),
      .init_t1_o(init_t1),
      .init_c1_o(init_c1),
      .cnt_up_o (cnt_up),
      .sel_xr_o (sel_xr),
      .ld_t_o   (ld_t),
      .ld_c_o   (ld_c)
    );

    assign strb[g] = {ld_x, init0, init_t1, init_c1, cnt_up, sel_xr, ld_t, ld_c};

    // Behavioural cosDU: real-valued term/accumulator, integer term counter.
    int  cnt;
    real xr, t, c;
    assign cnt8_s[g] = (cnt == N_TERMS);

    always @(posedge clk or negedge rst_n[g]) begin
      if (!rst_n[g]) begin
        cnt <= 0; xr <= 0.0; t <= 0.0; c <= 0.0;
      end else begin
        if (ld_x)    xr  <= real'(x_in[g]) / 16384.0;
        if (init0)   cnt <= 0;
        if (init_t1) t   <= 1.0;
        if (init_c1) c   <= 1.0;
        if (cnt_up)  cnt <= cnt + 1;
        if (ld_t)    t   <= sel_xr ? t * lut(cnt) : t * xr * xr;
        if (ld_c)    c   <= (cnt % 2 == 1) ? c - t : c + t;
      end
    end

    // Monitor: per-run strobe accounting, settle-segment shape, result check.
    int cyc = 0, n_ldc = 0, n_cnt = 0, n_ldt = 0, n_load = 0, seg = 0;
    bit active = 0, prev_mul = 0, prev_sel = 0, prev_done = 0;

    always @(negedge clk) begin
      bit  mul;
      int  xq;
      real ec;
      if (!rst_n[g]) begin
        active = 0; prev_mul = 0; prev_done = 0;
      end else begin
        mul = busy_s[g] && !ld_x && !cnt_up && !ld_c;
        if (ld_x) begin
          active = 1; cyc = 0; n_ldc = 0; n_cnt = 0; n_ldt = 0;
          n_load++;
        end else if (active) begin
          cyc++;
        end
        if (cnt_up) n_cnt++;
        if (ld_c)   n_ldc++;
        if (ld_t)   n_ldt++;
        if (mul) begin
          if (!prev_mul || (sel_xr != prev_sel)) seg = 1;
          else seg++;
          if (ld_t) check($sformatf("ldt_segment_len[%0d]", g), seg, 1 + L, 0);
        end
        prev_mul = mul;
        prev_sel = sel_xr;
        if (ready_s[g]) check($sformatf("idle_strobes[%0d]", g), int'(strb[g]), 0, 0);
        if (done_s[g] && !prev_done) begin
          if ((g == 0) ? (qx0.size() == 0) : (qx1.size() == 0)) begin
            fail($sformatf("unexpected_done[%0d]", g));
          end else begin
            xq = (g == 0) ? qx0.pop_front() : qx1.pop_front();
            ec = $cos(real'(xq) / 16384.0);
            check($sformatf("latency[%0d]", g), cyc, 1 + N_TERMS * (4 + 2 * L), 0);
            check($sformatf("ldc_count[%0d]", g), n_ldc, N_TERMS, 0);
            check($sformatf("cntup_count[%0d]", g), n_cnt, N_TERMS, 0);
            check($sformatf("ldt_count[%0d]", g), n_ldt, 2 * N_TERMS, 0);
            check($sformatf("rbus_x%0d[%0d]", xq, g), $rtoi(c * 16384.0), $rtoi(ec * 16384.0), 2);
          end
          active = 0;
        end
        prev_done = done_s[g];
      end
    end
  end

  task automatic do_start(input int idx, input int xq, input bit push);
    int k;
    for (k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (ready_s[idx]) break;
    end
    if (!ready_s[idx]) fail("ready_timeout");
    x_in[idx] = xq;
    start_s[idx] = 1'b1;
    exp_load[idx]++;
    if (push) begin
      if (idx == 0) qx0.push_back(xq);
      else qx1.push_back(xq);
    end
    @(posedge clk); #1;
    start_s[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx, output bit ok);
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done_s[idx]) begin ok = 1; break; end
    end
    if (!ok) fail("done_timeout");
  endtask

  task automatic finish_run(input int idx);
    bit ok;
    wait_done(idx, ok);
    if (ok) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check("done_held", int'(done_s[idx]), 1, 0);
      ack_s[idx] = 1'b1;
      @(negedge clk);
      ack_s[idx] = 1'b0;
      check("ready_after_ack", int'(ready_s[idx]), 1, 0);
    end
  endtask

  task automatic pulse(input int idx, input bit st, input bit ab, input bit ak);
    start_s[idx] = st; abort_s[idx] = ab; ack_s[idx] = ak;
    @(negedge clk);
    start_s[idx] = 1'b0; abort_s[idx] = 1'b0; ack_s[idx] = 1'b0;
  endtask

  task automatic check_idle(input int idx, input string name);
    check({name, "_ready"}, int'(ready_s[idx]), 1, 0);
    check({name, "_busy"},  int'(busy_s[idx]),  0, 0);
    check({name, "_done"},  int'(done_s[idx]),  0, 0);
    check({name, "_strb"},  int'(strb[idx]),    0, 0);
  endtask

  initial begin
    bit ok;
    int n;
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; start_s[i] = 1'b0; abort_s[i] = 1'b0; ack_s[i] = 1'b0;
      x_in[i] = 0; exp_load[i] = 0;
    end
    #12;
    check_idle(0, "reset0");
    check_idle(1, "reset1");
    @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // x = 0 and x = 1.0 at LAT_MUL=0
    do_start(0, 0, 1);      finish_run(0);
    do_start(0, 16384, 1);  finish_run(0);

    // LAT_MUL=3
    do_start(1, 16384, 1);  finish_run(1);
    do_start(1, $urandom_range(0, 24575), 1); finish_run(1);

    // start pulses and ack while busy are ignored
    do_start(0, 16384, 1);
    repeat (3) @(negedge clk);
    pulse(0, 1, 0, 0);
    n = 0;
    while (!strb[0][2] && n < 40) begin @(negedge clk); n++; end
    check("saw_mulr", int'(strb[0][2]), 1, 0);
    pulse(0, 0, 0, 1);
    repeat (8) @(negedge clk);
    pulse(0, 1, 0, 0);
    finish_run(0);
    repeat (4) @(negedge clk);
    check("no_queued_start", gi[0].n_load, exp_load[0], 0);
    check("no_queued_ready", int'(ready_s[0]), 1, 0);

    // start together with ack in DONE is dropped
    do_start(0, $urandom_range(0, 24575), 1);
    wait_done(0, ok);
    pulse(0, 1, 0, 1);
    check("start_ack_ready", int'(ready_s[0]), 1, 0);
    repeat (4) @(negedge clk);
    check("start_ack_loads", gi[0].n_load, exp_load[0], 0);

    // abort with ack and start in DONE
    do_start(0, $urandom_range(0, 24575), 1);
    wait_done(0, ok);
    pulse(0, 1, 1, 1);
    repeat (3) @(negedge clk);
    check_idle(0, "abort_in_done");
    check("abort_done_loads", gi[0].n_load, exp_load[0], 0);

    // abort beats start in IDLE
    @(negedge clk);
    pulse(0, 1, 1, 0);
    repeat (3) @(negedge clk);
    check("abort_start_loads", gi[0].n_load, exp_load[0], 0);

    // abort in the 3rd MULR
    do_start(0, 16384, 0);
    n = 0;
    for (int k = 0; k < 100 && n < 3; k++) begin
      bit was;
      was = strb[0][2];
      @(negedge clk);
      if (strb[0][2] && !was) n++;
    end
    check("third_mulr", n, 3, 0);
    check("abort_cycle_ldc", int'(strb[0][0]), 0, 0);
    pulse(0, 0, 1, 0);
    check_idle(0, "after_abort");
    check("abort_ldc_total", gi[0].n_ldc, 2, 0);
    do_start(0, 16384, 1);  finish_run(0);

    // random-point abort at LAT_MUL=3
    do_start(1, $urandom_range(0, 24575), 0);
    repeat ($urandom_range(1, 60)) @(negedge clk);
    pulse(1, 0, 1, 0);
    check_idle(1, "abort_rand");
    do_start(1, $urandom_range(0, 24575), 1); finish_run(1);

    // async reset during the 4th ACC
    do_start(0, $urandom_range(0, 24575), 0);
    n = 0;
    for (int k = 0; k < 100 && n < 4; k++) begin
      @(negedge clk);
      if (strb[0][0]) n++;
    end
    check("fourth_acc", n, 4, 0);
    #1 rst_n[0] = 1'b0;
    #1 check_idle(0, "async_rst");
    @(negedge clk);
    rst_n[0] = 1'b1;
    do_start(0, 16384, 1);  finish_run(0);

    // randomized runs on both instances
    for (int i = 0; i < 5; i++) begin
      do_start(0, $urandom_range(0, 24575), 1); finish_run(0);
      do_start(1, $urandom_range(0, 24575), 1); finish_run(1);
    end

    repeat (4) @(negedge clk);
    check("sb_drain0", qx0.size(), 0, 0);
    check("sb_drain1", qx1.size(), 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
